// File: rtl/rrp_pkg.sv
// Shared constants and types for the redundant-radix (signed-digit) datapath blocks.
package rrp_pkg;

    // log2 of a power-of-two radix
    function automatic int unsigned calc_k(input int unsigned radix);
        int unsigned k;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if ((radix >> i) > 1) k = i + 1;
        end
        return k;
    endfunction

    function automatic int unsigned calc_d(input int unsigned radix);
        return calc_k(radix) + 1;
    endfunction

    function automatic int unsigned calc_b(input int unsigned radix, input int unsigned width);
        return width * calc_k(radix) + 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/rrp_otf_step.sv
// One on-the-fly conversion step: shifts Q/QM left by one digit and appends a K-bit field.
module rrp_otf_step
    import rrp_pkg::*;
#(
    parameter int unsigned RADIX = 4,
    parameter int unsigned B     = 9,
    localparam int unsigned K    = calc_k(RADIX)
) (
    input  logic [B-1:0] q,
    input  logic [B-1:0] qm,
    input  logic [K:0]   d,
    output logic [B-1:0] q_next,
    output logic [B-1:0] qm_next
);

    // Low K bits of d equal RADIX+d for negative digits, so one field serves both signs.
    logic [K-1:0] d_lo;
    logic [K-1:0] d_lo_m1;

    assign d_lo    = d[K-1:0];
    assign d_lo_m1 = d_lo - K'(1);

    always_comb begin
        q_next  = q;
        qm_next = qm;
        if (d[K]) begin
            q_next  = {qm[B-K-1:0], d_lo};
            qm_next = {qm[B-K-1:0], d_lo_m1};
        end else if (d == '0) begin
            q_next  = {q[B-K-1:0], {K{1'b0}}};
            qm_next = {qm[B-K-1:0], {K{1'b1}}};
        end else begin
            q_next  = {q[B-K-1:0], d_lo};
            qm_next = {q[B-K-1:0], d_lo_m1};
        end
    end

endmodule

// File: rtl/rrp_otf_conv.sv
// Digit-serial MSD-first signed-digit to two's-complement converter (on-the-fly, no CPA).
// When fed adder sums of N digits, instantiate with WIDTH = N+1.
module rrp_otf_conv
    import rrp_pkg::*;
#(
    parameter int unsigned RADIX = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned K    = calc_k(RADIX),
    localparam int unsigned D    = calc_d(RADIX),
    localparam int unsigned B    = calc_b(RADIX, WIDTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [D-1:0] d_in,
    output logic         out_valid,
    output logic [B-1:0] q_out,
    output logic         err
);

    localparam int unsigned CW            = $clog2(WIDTH);
    localparam logic [D-1:0] NEG_RADIX    = {1'b1, {K{1'b0}}};

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [B-1:0]   q, q_nxt;
    logic [B-1:0]   qm, qm_nxt;
    logic [B-1:0]   q_out_nxt;
    logic           out_valid_nxt;
    logic           err_nxt;

    logic           start;
    logic           bad_digit;
    logic [D-1:0]   d_eff;
    logic [B-1:0]   step_q_in, step_qm_in;
    logic [B-1:0]   step_q, step_qm;

    // A new operand begins from Q=0, QM=-1 regardless of what the registers hold.
    assign start      = in_valid & in_first;
    assign bad_digit  = (d_in == NEG_RADIX);
    assign d_eff      = bad_digit ? '0 : d_in;
    assign step_q_in  = start ? '0 : q;
    assign step_qm_in = start ? '1 : qm;

    rrp_otf_step #(
        .RADIX (RADIX),
        .B     (B)
    ) u_step (
        .q       (step_q_in),
        .qm      (step_qm_in),
        .d       (d_eff),
        .q_next  (step_q),
        .qm_next (step_qm)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            q_out     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            q         <= q_nxt;
            qm        <= qm_nxt;
            q_out     <= q_out_nxt;
            out_valid <= out_valid_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        q_nxt         = q;
        qm_nxt        = qm;
        q_out_nxt     = q_out;
        out_valid_nxt = 1'b0;
        err_nxt       = err;

        if (in_valid) begin
            if (bad_digit) err_nxt = 1'b1;
            case (state)
                IDLE: begin
                    if (in_first) begin
                        q_nxt     = step_q;
                        qm_nxt    = step_qm;
                        cnt_nxt   = CW'(1);
                        state_nxt = ACC;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                ACC: begin
                    q_nxt  = step_q;
                    qm_nxt = step_qm;
                    if (in_first) begin
                        // abandon the partial operand and restart on this digit
                        err_nxt = 1'b1;
                        cnt_nxt = CW'(1);
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        q_out_nxt     = step_q;
                        out_valid_nxt = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
